// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types for the LC-3 register file
package regfile_pkg;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_CLEAR,
        RF_DUMP
    } rf_state_t;

endpackage

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - bulk-clear / register-dump sequencer and index counter
module regfile_seq_ctrl
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 8,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CLR_REQ,
    input  logic              DUMP_REQ,
    input  logic              DUMP_READY,
    output rf_state_t         state,
    output logic [ADDR_W-1:0] idx,
    output logic              BUSY,
    output logic              DUMP_VALID,
    output logic              clr_we
);

    // Terminal index is the last real register, not the top of the index space.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= RF_IDLE;
            idx        <= '0;
            BUSY       <= 1'b0;
            DUMP_VALID <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    idx <= '0;
                    if (CLR_REQ) begin
                        state <= RF_CLEAR;
                        BUSY  <= 1'b1;
                    end else if (DUMP_REQ) begin
                        state      <= RF_DUMP;
                        DUMP_VALID <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state <= RF_IDLE;
                        idx   <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RF_DUMP: begin
                    if (DUMP_READY) begin
                        if (idx == LAST_IDX) begin
                            state      <= RF_IDLE;
                            idx        <= '0;
                            DUMP_VALID <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= RF_IDLE;
                    idx        <= '0;
                    BUSY       <= 1'b0;
                    DUMP_VALID <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we = (state == RF_CLEAR);

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - LC-3 register file with bypass, bulk clear and debug dump port
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_REG,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] BUS,
    input  logic [ADDR_W-1:0] SR1,
    input  logic [ADDR_W-1:0] SR2,
    output logic [DATA_W-1:0] SR1OUT,
    output logic [DATA_W-1:0] SR2OUT,
    input  logic              CLR_REQ,
    input  logic              DUMP_REQ,
    output logic              BUSY,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic [ADDR_W-1:0] DUMP_IDX,
    output logic [DATA_W-1:0] DUMP_DATA
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    rf_state_t         state;
    logic [ADDR_W-1:0] idx;
    logic              clr_we;
    logic              dr_valid;
    logic              bypass_en;
    logic [DATA_W-1:0] arr1, arr2, arr_dump;

    regfile_seq_ctrl #(.NUM_REGS(NUM_REGS)) u_ctrl (
        .Clk        (Clk),
        .Reset      (Reset),
        .CLR_REQ    (CLR_REQ),
        .DUMP_REQ   (DUMP_REQ),
        .DUMP_READY (DUMP_READY),
        .state      (state),
        .idx        (idx),
        .BUSY       (BUSY),
        .DUMP_VALID (DUMP_VALID),
        .clr_we     (clr_we)
    );

    assign dr_valid = (int'(DR) < NUM_REGS);

    // The clear engine owns the write port for its whole run; bus writes are dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_we) begin
                    if (idx == ADDR_W'(i)) regs[i] <= '0;
                end else if (LD_REG && DR == ADDR_W'(i)) begin
                    regs[i] <= BUS;
                end
            end
        end
    end

    // Decoded muxes so indices beyond NUM_REGS read as zero.
    always_comb begin
        arr1     = '0;
        arr2     = '0;
        arr_dump = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (SR1 == ADDR_W'(i)) arr1 = regs[i];
            if (SR2 == ADDR_W'(i)) arr2 = regs[i];
            if (idx == ADDR_W'(i)) arr_dump = regs[i];
        end
    end

    assign bypass_en = BYPASS && (state != RF_CLEAR) && LD_REG && dr_valid;
    assign SR1OUT    = (bypass_en && DR == SR1) ? BUS : arr1;
    assign SR2OUT    = (bypass_en && DR == SR2) ? BUS : arr2;
    assign DUMP_IDX  = idx;
    assign DUMP_DATA = arr_dump;

endmodule
